// File: rtl/alu_result_checker.sv
// Response checker for the ALU harness: recomputes each sampled result, counts passes/fails
// and logs every mismatch into a small first-word-fall-through FIFO.
module alu_result_checker #(
  parameter int unsigned N_VECTORS = 8,
  parameter int unsigned LOG_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        in_valid_i,
  input  logic [63:0] in_a_i,
  input  logic [63:0] in_b_i,
  input  logic [3:0]  in_op_i,
  input  logic [63:0] in_f_i,
  input  logic        in_z_i,
  input  logic        log_rd_i,
  output logic        log_valid_o,
  output logic [15:0] log_data_o,
  output logic        log_overflow_o,
  output logic [8:0]  pass_count_o,
  output logic [8:0]  fail_count_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int unsigned AW = $clog2(LOG_DEPTH);
  localparam logic [7:0]  LastIdx   = 8'(N_VECTORS - 1);
  localparam logic [AW:0] CountFull = (AW + 1)'(LOG_DEPTH);
  localparam logic [AW:0] CountOne  = (AW + 1)'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e      state_q;
  logic        busy_q, done_q;
  logic [7:0]  idx_q;
  logic        accept;

  logic        s1_valid_q;
  logic [63:0] s1_a_q, s1_b_q, s1_f_q;
  logic [3:0]  s1_op_q;
  logic        s1_z_q;
  logic [7:0]  s1_idx_q;

  logic [63:0] exp_f;
  logic        exp_z, illegal_op, f_mismatch, z_mismatch, fail;
  logic [15:0] entry;

  logic [8:0]  pass_q, fail_q;
  logic        push_q;
  logic [15:0] push_entry_q;

  logic [15:0]   mem_q [LOG_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q;
  logic          full, pop, do_write;

  assign accept = in_valid_i && ((state_q == StIdle) || (state_q == StRun));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= 8'd0;
    end else begin
      case (state_q)
        StIdle, StRun: begin
          if (accept) begin
            idx_q  <= idx_q + 8'd1;
            busy_q <= 1'b1;
            state_q <= (idx_q == LastIdx) ? StDrain : StRun;
          end
        end
        StDrain: begin
          // Hold until the final transaction has left stage 1 and updated the counters.
          if (!s1_valid_q) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= accept;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      s1_a_q   <= in_a_i;
      s1_b_q   <= in_b_i;
      s1_op_q  <= in_op_i;
      s1_f_q   <= in_f_i;
      s1_z_q   <= in_z_i;
      s1_idx_q <= idx_q;
    end
  end

  always_comb begin
    exp_f      = 64'd0;
    illegal_op = 1'b0;
    case (s1_op_q)
      4'b0000: exp_f = s1_a_q & s1_b_q;
      4'b0001: exp_f = s1_a_q | s1_b_q;
      4'b0010: exp_f = s1_a_q + s1_b_q;
      4'b0110: exp_f = s1_a_q - s1_b_q;
      4'b0111: exp_f = s1_b_q;
      4'b1100: exp_f = ~(s1_a_q | s1_b_q);
      default: illegal_op = 1'b1;
    endcase
    exp_z      = (exp_f == 64'd0);
    f_mismatch = (s1_f_q != exp_f);
    z_mismatch = (s1_z_q != exp_z);
    fail       = f_mismatch || z_mismatch || illegal_op;
    entry      = {s1_idx_q, s1_op_q, illegal_op, z_mismatch, f_mismatch, 1'b0};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pass_q       <= 9'd0;
      fail_q       <= 9'd0;
      push_q       <= 1'b0;
      push_entry_q <= 16'd0;
    end else begin
      push_q <= s1_valid_q && fail;
      if (s1_valid_q) begin
        if (fail) begin
          fail_q       <= fail_q + 9'd1;
          push_entry_q <= entry;
        end else begin
          pass_q <= pass_q + 9'd1;
        end
      end
    end
  end

  // A full log still accepts a push when the head is popped in the same cycle.
  assign full     = (count_q == CountFull);
  assign pop      = log_rd_i && (count_q != '0);
  assign do_write = push_q && (!full || pop);

  always_comb begin
    count_d = count_q;
    if (do_write && !pop) begin
      count_d = count_q + CountOne;
    end else if (pop && !do_write) begin
      count_d = count_q - CountOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (do_write) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push_q && full && !pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_write) begin
      mem_q[wr_ptr_q] <= push_entry_q;
    end
  end

  assign log_valid_o    = (count_q != '0);
  assign log_data_o     = log_valid_o ? mem_q[rd_ptr_q] : 16'd0;
  assign log_overflow_o = overflow_q;
  assign pass_count_o   = pass_q;
  assign fail_count_o   = fail_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

endmodule
